// File: rtl/ram3_write_arbiter.sv
// Write-port sequencer for the 3R/1W register file: initialises every word after
// reset or clear, then shares the single write port among clients by round-robin.
module ram3_write_arbiter #(
  parameter int                Width        = 8,
  parameter int                AddressWidth = 4,
  parameter int                Requesters   = 4,
  parameter logic [Width-1:0]  InitValue    = {Width{1'b0}},
  localparam int               IdW          = $clog2(Requesters)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             clear,
  input  logic [Requesters-1:0]            req_valid,
  input  logic [Requesters*AddressWidth-1:0] req_addr,
  input  logic [Requesters*Width-1:0]      req_data,
  output logic [Requesters-1:0]            req_ready,
  output logic                             we,
  output logic [AddressWidth-1:0]          waddr,
  output logic [Width-1:0]                 D,
  output logic                             busy,
  output logic [IdW-1:0]                   grant_id
);

  // Handshake: a client's write is accepted in the cycle where req_valid[i] &
  // req_ready[i] are both high; ready is never high in INIT, under rst, or with clear.

  typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_t;

  state_t                  state;
  logic [AddressWidth-1:0] cnt;
  logic [IdW-1:0]          ptr;
  logic                    found;
  logic [IdW-1:0]          gid;
  logic                    accept;

  // First valid client at or after the pointer, wrapping around.
  always_comb begin
    found = 1'b0;
    gid   = '0;
    for (int k = 0; k < Requesters; k++) begin
      if (!found && req_valid[(int'(ptr) + k) % Requesters]) begin
        found = 1'b1;
        gid   = IdW'((int'(ptr) + k) % Requesters);
      end
    end
  end

  assign accept   = (state == RUN) && !clear && !rst && found;
  assign busy     = (state == INIT) || rst;
  assign grant_id = gid;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[gid] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= INIT;
      cnt   <= '0;
      ptr   <= '0;
      we    <= 1'b0;
      waddr <= '0;
      D     <= '0;
    end else begin
      case (state)
        INIT: begin
          we    <= 1'b1;
          waddr <= cnt;
          D     <= InitValue;
          if (cnt == {AddressWidth{1'b1}}) begin
            cnt   <= '0;
            state <= RUN;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RUN: begin
          if (clear) begin
            we    <= 1'b0;
            cnt   <= '0;
            state <= INIT;
          end else if (accept) begin
            we    <= 1'b1;
            waddr <= req_addr[int'(gid)*AddressWidth +: AddressWidth];
            D     <= req_data[int'(gid)*Width +: Width];
            ptr   <= (gid == IdW'(Requesters - 1)) ? '0 : gid + 1'b1;
          end else begin
            we <= 1'b0;
          end
        end
        default: begin
          we    <= 1'b0;
          state <= INIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram3_write_arbiter.sv
// Directed bench for ram3_write_arbiter: vector table for round-robin traffic plus
// hand sequences for reset, init sweeps, clear and reset mid-sweep.
module tb_ram3_write_arbiter;

  logic        clk;
  logic        rst;
  logic        clear;
  logic [3:0]  req_valid;
  logic [15:0] req_addr;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        we;
  logic [3:0]  waddr;
  logic [7:0]  D;
  logic        busy;
  logic [1:0]  grant_id;

  int n_chk = 0;
  int n_err = 0;

  ram3_write_arbiter #(
    .Width(8), .AddressWidth(4), .Requesters(4), .InitValue(8'h00)
  ) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready), .we(we), .waddr(waddr), .D(D),
    .busy(busy), .grant_id(grant_id)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        clr;
    logic [3:0]  valid;
    logic [15:0] addr;
    logic [31:0] data;
    logic [3:0]  ready;
    logic [1:0]  gid;
    logic        we;
    logic [3:0]  waddr;
    logic [7:0]  d;
  } vec_t;

  vec_t vt [0:21];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic clr, input logic [3:0] valid, input logic [15:0] addr,
                              input logic [31:0] data, input logic [3:0] ready, input logic [1:0] gid,
                              input logic w, input logic [3:0] wa, input logic [7:0] d);
    vec_t v;
    v.clr = clr; v.valid = valid; v.addr = addr; v.data = data;
    v.ready = ready; v.gid = gid; v.we = w; v.waddr = wa; v.d = d;
    return v;
  endfunction

  // driver: one table vector per cycle, combinational checks before the edge
  task automatic apply_vec(input int i);
    clear     = vt[i].clr;
    req_valid = vt[i].valid;
    req_addr  = vt[i].addr;
    req_data  = vt[i].data;
    #1;
    chk($sformatf("v%0d ready", i), 32'(req_ready), 32'(vt[i].ready));
    if (vt[i].ready != 4'b0000) chk($sformatf("v%0d grant_id", i), 32'(grant_id), 32'(vt[i].gid));
    chk($sformatf("v%0d busy", i), 32'(busy), 32'd0);
    step();
    chk($sformatf("v%0d we", i), 32'(we), 32'(vt[i].we));
    chk($sformatf("v%0d waddr", i), 32'(waddr), 32'(vt[i].waddr));
    chk($sformatf("v%0d D", i), 32'(D), 32'(vt[i].d));
  endtask

  // Init sweep: checks the first n addresses; clear pulsed at cycle clear_at is ignored.
  task automatic sweep(input int n, input int clear_at, input string tag);
    req_valid = 4'b1111;
    for (int c = 0; c < n; c++) begin
      clear = (c == clear_at);
      #1;
      chk($sformatf("%s c%0d busy", tag, c), 32'(busy), 32'd1);
      chk($sformatf("%s c%0d ready", tag, c), 32'(req_ready), 32'd0);
      step();
      chk($sformatf("%s c%0d we", tag, c), 32'(we), 32'd1);
      chk($sformatf("%s c%0d waddr", tag, c), 32'(waddr), 32'(c));
      chk($sformatf("%s c%0d D", tag, c), 32'(D), 32'h00);
    end
    clear     = 1'b0;
    req_valid = 4'b0000;
  endtask

  initial begin
    vt[0]  = mk(0, 4'b0100, 16'h0500, 32'h00A50000, 4'b0100, 2'd2, 1, 4'h5, 8'hA5);
    vt[1]  = mk(0, 4'b0000, 16'h0000, 32'h00000000, 4'b0000, 2'd0, 0, 4'h5, 8'hA5);
    vt[2]  = mk(0, 4'b1000, 16'h9000, 32'h3C000000, 4'b1000, 2'd3, 1, 4'h9, 8'h3C);
    for (int k = 0; k < 8; k++)
      vt[3+k] = mk(0, 4'b1111, 16'hFEDC, 32'h44332211, 4'(1 << (k % 4)), 2'(k % 4),
                   1, 4'(12 + k % 4), 8'(8'h11 * (k % 4 + 1)));
    vt[11] = mk(0, 4'b0010, 16'h0060, 32'h00006600, 4'b0010, 2'd1, 1, 4'h6, 8'h66);
    vt[12] = mk(0, 4'b1010, 16'h3010, 32'h83008100, 4'b1000, 2'd3, 1, 4'h3, 8'h83);
    vt[13] = mk(0, 4'b1010, 16'h3010, 32'h83008100, 4'b0010, 2'd1, 1, 4'h1, 8'h81);
    vt[14] = mk(0, 4'b1010, 16'h3010, 32'h83008100, 4'b1000, 2'd3, 1, 4'h3, 8'h83);
    vt[15] = mk(0, 4'b0100, 16'h0A00, 32'h005A0000, 4'b0100, 2'd2, 1, 4'hA, 8'h5A);
    vt[16] = mk(1, 4'b0001, 16'h0002, 32'h000000E1, 4'b0000, 2'd0, 0, 4'hA, 8'h5A);
    vt[17] = mk(0, 4'b1001, 16'h7004, 32'hD70000C4, 4'b1000, 2'd3, 1, 4'h7, 8'hD7);
    vt[18] = mk(0, 4'b0001, 16'h7004, 32'hD70000C4, 4'b0001, 2'd0, 1, 4'h4, 8'hC4);
    vt[19] = mk(1, 4'b0000, 16'h0000, 32'h00000000, 4'b0000, 2'd0, 0, 4'h4, 8'hC4);
    vt[20] = mk(0, 4'b1001, 16'h7004, 32'hD70000C4, 4'b0001, 2'd0, 1, 4'h4, 8'hC4);
    vt[21] = mk(0, 4'b0000, 16'h0000, 32'h00000000, 4'b0000, 2'd0, 0, 4'h4, 8'hC4);

    rst = 1'b1; clear = 1'b0; req_valid = 4'b1111; req_addr = '0; req_data = '0;
    for (int r = 0; r < 2; r++) begin
      step();
      chk($sformatf("rst%0d we", r), 32'(we), 32'd0);
      chk($sformatf("rst%0d waddr", r), 32'(waddr), 32'd0);
      chk($sformatf("rst%0d D", r), 32'(D), 32'd0);
      chk($sformatf("rst%0d busy", r), 32'(busy), 32'd1);
      chk($sformatf("rst%0d ready", r), 32'(req_ready), 32'd0);
    end
    rst = 1'b0;
    sweep(16, -1, "init");

    // single client, round-robin, sparse wrap, then clear with client 0 waiting
    for (int i = 0; i <= 16; i++) apply_vec(i);
    sweep(16, 5, "clr_sweep");
    // pointer kept at 3 across the clear: client 3 beats client 0
    for (int i = 17; i <= 19; i++) apply_vec(i);

    // reset in the middle of a sweep
    sweep(8, -1, "part");
    rst = 1'b1;
    #1;
    chk("midrst busy", 32'(busy), 32'd1);
    step();
    chk("midrst we", 32'(we), 32'd0);
    chk("midrst waddr", 32'(waddr), 32'd0);
    chk("midrst D", 32'(D), 32'd0);
    rst = 1'b0;
    sweep(16, -1, "resweep");
    // pointer back to 0 after reset
    for (int i = 20; i <= 21; i++) apply_vec(i);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
